// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between requester front-ends and rr_resource_arbiter.
//   req      per-requester level request
//   rel      owner's one-cycle release strobe
//   gnt      one-hot grant
//   gnt_id   binary index of the current owner
//   busy     resource owned
//   preempt  one-cycle pulse when a grant is revoked by hold timeout
// master: requester side, slave: arbiter side.
interface rr_resource_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic            rel;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            preempt;

  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_id,
    output busy,
    output preempt
  );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// A grant is held until the owner pulses rel, drops its req, or has held it for
// MAX_HOLD cycles while another requester waits (MAX_HOLD = 0 disables the limit).
// After a grant ends the arbiter spends TURNAROUND cycles in GAP, then one cycle
// in IDLE where arbitration is evaluated, so gnt is low for TURNAROUND + 1 cycles.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of rr_resource_arbiter_if (req, rel in; gnt, gnt_id, busy,
//          preempt out)
module rr_resource_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned TURNAROUND = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_resource_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned GapW  = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            preempt_q, preempt_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            owner_req;
  logic            hold_hit;

  // First requester at or after last+1, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_q) + i) % N;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign owner_req = bus.req[id_q];
  // ">=" so a saturated counter still times out once someone starts waiting.
  assign hold_hit  = (MAX_HOLD > 0) && (hold_q >= HoldW'(MAX_HOLD - 1)) &&
                     (|(bus.req & ~gnt_q));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d         = '0;
          gnt_d[win_id] = 1'b1;
          id_d          = win_id;
          hold_d        = '0;
          state_d       = StBusy;
        end
      end
      StBusy: begin
        if (hold_q != HoldW'(MAX_HOLD)) begin
          hold_d = hold_q + HoldW'(1);
        end
        if (bus.rel || !owner_req || hold_hit) begin
          gnt_d     = '0;
          last_d    = id_q;
          hold_d    = '0;
          gap_d     = '0;
          // Release or a dropped request take precedence over the timeout.
          preempt_d = !bus.rel && owner_req;
          state_d   = (TURNAROUND > 0) ? StGap : StIdle;
        end
      end
      StGap: begin
        if (gap_q == GapW'(TURNAROUND - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(N - 1);
      hold_q    <= '0;
      gap_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = |gnt_q;
  assign bus.preempt = preempt_q;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_busy:   assert property (@(posedge clk) disable iff (!rst_n) bus.busy == |gnt_q);
  a_id:     assert property (@(posedge clk) disable iff (!rst_n) bus.busy |-> gnt_q[id_q]);
`endif
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Bench for rr_resource_arbiter: two instances (MAX_HOLD=16/TURNAROUND=1 and
// MAX_HOLD=4/TURNAROUND=0) share stimulus. Directed scenarios use constant
// expectations; a random phase compares both against a behavioural model.
module tb_rr_resource_arbiter;
  localparam int MH [2] = '{16, 4};
  localparam int TA [2] = '{1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       rel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit pre_seen_a;

  // Reference model state: owner -1 means nobody holds the resource.
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int m_gap   [2];
  bit m_pre   [2];

  rr_resource_arbiter_if #(.N(4)) bus_a ();
  rr_resource_arbiter_if #(.N(4)) bus_b ();

  assign bus_a.req = req;
  assign bus_a.rel = rel;
  assign bus_b.req = req;
  assign bus_b.rel = rel;

  rr_resource_arbiter #(.N(4), .MAX_HOLD(16), .TURNAROUND(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  rr_resource_arbiter #(.N(4), .MAX_HOLD(4), .TURNAROUND(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model, stepped on every clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          m_owner[d] = -1;
          m_last[d]  = 3;
          m_held[d]  = 0;
          m_gap[d]   = 0;
          m_pre[d]   = 1'b0;
        end else begin
          m_pre[d] = 1'b0;
          if (m_owner[d] >= 0) begin
            if (rel || !req[m_owner[d]]) begin
              m_last[d]  = m_owner[d];
              m_owner[d] = -1;
              m_gap[d]   = TA[d];
            end else if (MH[d] > 0 && m_held[d] >= MH[d] &&
                         (req & ~(4'b0001 << m_owner[d])) != 4'b0000) begin
              m_pre[d]   = 1'b1;
              m_last[d]  = m_owner[d];
              m_owner[d] = -1;
              m_gap[d]   = TA[d];
            end else begin
              m_held[d]++;
            end
          end else if (m_gap[d] > 0) begin
            m_gap[d]--;
          end else begin
            for (int k = 1; k <= 4; k++) begin
              if (m_owner[d] < 0 && req[(m_last[d] + k) % 4]) begin
                m_owner[d] = (m_last[d] + k) % 4;
                m_held[d]  = 1;
              end
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    pre_seen_a |= bus_a.preempt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt_a();
    int n = 0;
    while (bus_a.gnt == 4'b0000 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_gnt_b();
    int n = 0;
    while (bus_b.gnt == 4'b0000 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic compare_model(input int d);
    logic [3:0] e_gnt;
    logic [3:0] g;
    logic [1:0] gid;
    logic       gb, gp;
    e_gnt = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
    g   = (d == 0) ? bus_a.gnt : bus_b.gnt;
    gid = (d == 0) ? bus_a.gnt_id : bus_b.gnt_id;
    gb  = (d == 0) ? bus_a.busy : bus_b.busy;
    gp  = (d == 0) ? bus_a.preempt : bus_b.preempt;
    check($sformatf("rnd_gnt%0d", d), g, e_gnt);
    check($sformatf("rnd_busy%0d", d), gb, m_owner[d] >= 0);
    check($sformatf("rnd_pre%0d", d), gp, m_pre[d]);
    if (m_owner[d] >= 0) check($sformatf("rnd_id%0d", d), gid, m_owner[d]);
  endtask

  initial begin
    int za, zb, cnt;
    logic [3:0] ga, gb;

    // Reset values, then first grant and turnaround after release.
    do_reset();
    check("rst_gnt_a", bus_a.gnt, 0);
    check("rst_busy_a", bus_a.busy, 0);
    check("rst_pre_a", bus_a.preempt, 0);
    check("rst_id_a", bus_a.gnt_id, 0);
    check("rst_gnt_b", bus_b.gnt, 0);
    req = 4'b0101;
    cyc();
    check("first_gnt_a", bus_a.gnt, 4'b0001);
    check("first_id_a", bus_a.gnt_id, 0);
    check("first_busy_a", bus_a.busy, 1);
    check("first_gnt_b", bus_b.gnt, 4'b0001);
    rel = 1'b1;
    cyc();
    rel = 1'b0;
    check("rel_gnt_a", bus_a.gnt, 0);
    check("rel_pre_a", bus_a.preempt, 0);
    za = 1; zb = 1; ga = '0; gb = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ga == 4'b0000) begin
        if (bus_a.gnt != 4'b0000) ga = bus_a.gnt; else za++;
      end
      if (gb == 4'b0000) begin
        if (bus_b.gnt != 4'b0000) gb = bus_b.gnt; else zb++;
      end
    end
    check("gap_len_a", za, 2);
    check("gap_len_b", zb, 1);
    check("second_gnt_a", ga, 4'b0100);
    check("second_gnt_b", gb, 4'b0100);
    check("second_id_a", bus_a.gnt_id, 2);

    // Rotation with all requesting and prompt releases.
    do_reset();
    req = 4'b1111;
    pre_seen_a = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt_a();
      check($sformatf("rot_id%0d", g), bus_a.gnt_id, g % 4);
      check($sformatf("rot_gnt%0d", g), bus_a.gnt, 4'b0001 << (g % 4));
      cyc();
      cyc();
      rel = 1'b1;
      cyc();
      rel = 1'b0;
    end
    check("rot_no_preempt", pre_seen_a, 0);

    // Hold timeout with a waiter.
    do_reset();
    req = 4'b1010;
    wait_gnt_a();
    check("hold_gnt", bus_a.gnt, 4'b0010);
    cnt = 0;
    while (bus_a.gnt == 4'b0010 && cnt < 40) begin
      cnt++;
      cyc();
    end
    check("hold_cycles", cnt, 16);
    check("hold_preempt", bus_a.preempt, 1);
    cyc();
    check("hold_preempt_pulse", bus_a.preempt, 0);
    wait_gnt_a();
    check("hold_next_gnt", bus_a.gnt, 4'b1000);

    // No waiter: grant kept indefinitely, then a waiter triggers timeout.
    do_reset();
    req = 4'b0010;
    wait_gnt_a();
    pre_seen_a = 1'b0;
    repeat (120) cyc();
    check("long_gnt", bus_a.gnt, 4'b0010);
    check("long_no_preempt", pre_seen_a, 0);
    req = 4'b1010;
    cyc();
    check("late_waiter_gnt", bus_a.gnt, 0);
    check("late_waiter_pre", bus_a.preempt, 1);

    // Zero turnaround instance.
    do_reset();
    req = 4'b0011;
    wait_gnt_b();
    check("ta0_gnt0", bus_b.gnt, 4'b0001);
    rel = 1'b1;
    cyc();
    rel = 1'b0;
    check("ta0_gap", bus_b.gnt, 0);
    cyc();
    check("ta0_gnt1", bus_b.gnt, 4'b0010);

    // Owner drops its request; then asynchronous reset mid-grant.
    do_reset();
    req = 4'b0100;
    wait_gnt_a();
    check("drop_gnt2", bus_a.gnt, 4'b0100);
    req = 4'b0101;
    repeat (3) cyc();
    req = 4'b0001;
    cyc();
    check("drop_gnt", bus_a.gnt, 0);
    check("drop_pre", bus_a.preempt, 0);
    wait_gnt_a();
    check("drop_next", bus_a.gnt, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt", bus_a.gnt, 0);
    check("async_busy", bus_a.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    wait_gnt_a();
    check("post_rst_id", bus_a.gnt_id, 0);

    // Random phase against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      compare_model(0);
      compare_model(1);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 23) == 0) req[b] = ~req[b];
      end
      rel = ($urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
